next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// ----------------------------------------------------------------------------
// next_pc_unit
//   Fetch-PC generator with an optional direct-mapped BTB and 2-bit
//   saturating direction counters. A mispredict resolved in EX redirects
//   fetch in the same cycle it is seen and overrides a fetch stall.
//
//   Build option: define NEXT_PC_PRED_EN to build the BTB/counter tables.
//   Without it the unit is a static not-taken predictor (pred_taken = 0,
//   pred_target = pc + 4); redirect and stall behaviour is identical.
//
// Parameters
//   XLEN        datapath / PC width
//   BTB_ENTRIES predictor depth, power of two, 2..256
//   RESET_PC    fetch address after reset
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset_n        asynchronous active-low reset
//   stall          hold the fetch PC (IF/ID hazard)
//   ex_valid       EX-stage instruction valid
//   ex_is_ctrl     EX instruction is a branch/JAL/JALR (trains the tables)
//   ex_pc          PC of the EX instruction
//   ex_taken       resolved direction
//   ex_target      resolved target
//   ex_pred_taken  prediction that travelled down the pipe with ex_pc
//   ex_pred_target predicted target that travelled with ex_pc
//   pc             current fetch PC (registered)
//   pred_taken     prediction for pc (combinational)
//   pred_target    predicted next PC for pc
//   flush          mispredict, squash IF/ID and ID/EX this cycle
// ----------------------------------------------------------------------------

`ifdef NEXT_PC_PRED_EN
// One BTB entry. It sees every EX update together with a select that says
// whether the update addresses this index, and decides hit/allocate locally.
module next_pc_btb_entry #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 26
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             upd_en,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic             upd_taken,
   input  logic [XLEN-1:0]  upd_target,
   output logic             valid,
   output logic [TAG_W-1:0] tag,
   output logic [XLEN-1:0]  target,
   output logic [1:0]       ctr
);

   logic hit;
   assign hit = valid & (tag == upd_tag);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid  <= 1'b0;
         tag    <= '0;
         target <= '0;
         ctr    <= 2'b01;
      end else if (upd_en) begin
         if (hit) begin
            if (upd_taken) begin
               ctr    <= (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
               target <= upd_target;
            end else begin
               ctr    <= (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
            end
         end else if (upd_taken) begin
            // Miss on a taken branch: overwrite whatever lives here and
            // start weakly taken. Not-taken misses are not worth a slot.
            valid  <= 1'b1;
            tag    <= upd_tag;
            target <= upd_target;
            ctr    <= 2'b10;
         end
      end
   end

endmodule
`endif

module next_pc_unit #(
   parameter int unsigned      XLEN        = 32,
   parameter int unsigned      BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0]  RESET_PC    = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic            ex_is_ctrl,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic [XLEN-1:0] pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   output logic            flush
);

   // EX-stage resolution bundled for readability
   typedef struct packed {
      logic            valid;
      logic            is_ctrl;
      logic [XLEN-1:0] pc;
      logic            taken;
      logic [XLEN-1:0] target;
      logic            pred_taken;
      logic [XLEN-1:0] pred_target;
   } ex_res_t;

   ex_res_t         ex;
   logic            mispredict;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] ex_pc_plus4;
   logic [XLEN-1:0] pc_next;

   assign ex.valid       = ex_valid;
   assign ex.is_ctrl     = ex_is_ctrl;
   assign ex.pc          = ex_pc;
   assign ex.taken       = ex_taken;
   assign ex.target      = ex_target;
   assign ex.pred_taken  = ex_pred_taken;
   assign ex.pred_target = ex_pred_target;

   assign pc_plus4    = pc + XLEN'(4);
   assign ex_pc_plus4 = ex.pc + XLEN'(4);

   // Wrong direction, or right direction (taken) but wrong target. Evaluated
   // for non-control instructions too, so a false BTB hit gets squashed.
   assign mispredict = ex.valid &
                       ((ex.taken ^ ex.pred_taken) |
                        (ex.taken & (ex.target != ex.pred_target)));
   assign flush = mispredict;

   // ---------------------------------------------------------------------
   // Prediction
   // ---------------------------------------------------------------------
`ifdef NEXT_PC_PRED_EN
   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             upd;
   logic             rd_hit;

   logic [BTB_ENTRIES-1:0]            e_valid;
   logic [BTB_ENTRIES-1:0][TAG_W-1:0] e_tag;
   logic [BTB_ENTRIES-1:0][XLEN-1:0]  e_target;
   logic [BTB_ENTRIES-1:0][1:0]       e_ctr;

   assign rd_idx = pc[IDX_W+1:2];
   assign rd_tag = pc[XLEN-1:IDX_W+2];
   assign wr_idx = ex.pc[IDX_W+1:2];
   assign wr_tag = ex.pc[XLEN-1:IDX_W+2];

   // Training ignores stall; only real control-flow instructions train.
   assign upd = ex.valid & ex.is_ctrl;

   for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_btb
      next_pc_btb_entry #(
         .XLEN  (XLEN),
         .TAG_W (TAG_W)
      ) u_entry (
         .clk        (clk),
         .reset_n    (reset_n),
         .upd_en     (upd && (wr_idx == IDX_W'(i))),
         .upd_tag    (wr_tag),
         .upd_taken  (ex.taken),
         .upd_target (ex.target),
         .valid      (e_valid[i]),
         .tag        (e_tag[i]),
         .target     (e_target[i]),
         .ctr        (e_ctr[i])
      );
   end

   // Read side uses the registered table contents, so an update to the
   // same index this cycle only becomes visible on the next one.
   assign rd_hit      = e_valid[rd_idx] & (e_tag[rd_idx] == rd_tag);
   assign pred_taken  = rd_hit & e_ctr[rd_idx][1];
   assign pred_target = pred_taken ? e_target[rd_idx] : pc_plus4;
`else
   // Static not-taken: EX control flag has no table to train.
   logic unused_is_ctrl;
   assign unused_is_ctrl = ex.is_ctrl;

   assign pred_taken  = 1'b0;
   assign pred_target = pc_plus4;
`endif

   // ---------------------------------------------------------------------
   // Next fetch PC: mispredict beats stall beats prediction
   // ---------------------------------------------------------------------
   always_comb begin
      pc_next = pred_target;
      if (mispredict)
         pc_next = ex.taken ? ex.target : ex_pc_plus4;
      else if (stall)
         pc_next = pc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pc <= RESET_PC;
      else          pc <= pc_next;
   end

endmodule
